// File: rtl/ram_read_sequencer.sv
// ram_read_sequencer
// Queues read jobs (data-cycle counts) and drives ram_reader one job at a time.
// Each job is split into full blocks plus a partial block. The reader gets a
// one-cycle start pulse, and the sequencer waits for it to return idle. The job
// is then reported on a valid/ready done channel.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   cmd_cycles/valid/ready       job command input (FIFO push side)
//   rdr_full_blocks              full blocks for the current job -> ram_reader
//   rdr_partial_cycles           cycles of the trailing partial block -> ram_reader
//   rdr_start                    one-cycle launch pulse -> ram_reader
//   rdr_idle                     ram_reader idle status
//   done_cycles/seq/valid/ready  completion record output
//   jobs_completed               running count of accepted completion records
//   all_idle                     FIFO empty, FSM idle and reader idle
module ram_read_sequencer #(
  parameter int CYCLES_PER_BLOCK = 64,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cmd_cycles,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rdr_full_blocks,
  output logic [7:0]  rdr_partial_cycles,
  output logic        rdr_start,
  input  logic        rdr_idle,
  output logic [31:0] done_cycles,
  output logic [15:0] done_seq,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] jobs_completed,
  output logic        all_idle
);

  localparam int BLK_SH = $clog2(CYCLES_PER_BLOCK);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [31:0]      BLK_MASK = 32'(CYCLES_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [31:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        full_q, full_d;
  logic [7:0]         part_q, part_d;
  logic               start_q, start_d;
  logic [31:0]        done_cycles_q, done_cycles_d;
  logic [15:0]        done_seq_q, done_seq_d;
  logic [15:0]        seq_q, seq_d;
  logic [31:0]        jobs_q, jobs_d;

  logic               push, pop;
  logic [31:0]        head;

  assign cmd_ready          = (count_q < DEPTH_C);
  assign push               = cmd_valid && cmd_ready;
  assign pop                = (state_q == S_IDLE) && (count_q != '0);
  assign head               = mem_q[rd_ptr_q];

  assign rdr_full_blocks    = full_q;
  assign rdr_partial_cycles = part_q;
  assign rdr_start          = start_q;
  assign done_cycles        = done_cycles_q;
  assign done_seq           = done_seq_q;
  assign done_valid         = (state_q == S_REPORT);
  assign jobs_completed     = jobs_q;
  assign all_idle           = (count_q == '0) && (state_q == S_IDLE) && rdr_idle;

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    full_d        = full_q;
    part_d        = part_q;
    start_d       = 1'b0;
    done_cycles_d = done_cycles_q;
    done_seq_d    = done_seq_q;
    seq_d         = seq_q;
    jobs_d        = jobs_q;

    if (push) begin
      mem_d[wr_ptr_q] = cmd_cycles;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // Split values and the record fields are captured at pop time. They hold
    // until the next pop, so the reader and the done channel see stable data.
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      full_d        = head >> BLK_SH;
      part_d        = 8'(head & BLK_MASK);
      done_cycles_d = head;
      done_seq_d    = seq_q;
      seq_d         = seq_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = (head == 32'd0) ? S_REPORT : S_LAUNCH;
      end
      S_LAUNCH: begin
        // start is registered, so the pulse appears in the cycle after LAUNCH
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // While start is high the reader has not dropped idle yet, so the
        // idle seen in that cycle is stale and must be ignored.
        if (!start_q && rdr_idle) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (done_ready) begin
          jobs_d  = jobs_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= '0;
      part_q        <= '0;
      start_q       <= 1'b0;
      done_cycles_q <= '0;
      done_seq_q    <= '0;
      seq_q         <= '0;
      jobs_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      part_q        <= part_d;
      start_q       <= start_d;
      done_cycles_q <= done_cycles_d;
      done_seq_q    <= done_seq_d;
      seq_q         <= seq_d;
      jobs_q        <= jobs_d;
    end
  end

  // FIFO storage needs no reset; occupancy is governed by the pointers/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ram_read_sequencer.sv
module tb_ram_read_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] cmd_cycles = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] rdr_full_blocks;
  logic [7:0]  rdr_partial_cycles;
  logic        rdr_start;
  logic        rdr_idle = 1'b1;
  logic [31:0] done_cycles;
  logic [15:0] done_seq;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [31:0] jobs_completed;
  logic        all_idle;

  ram_read_sequencer #(.CYCLES_PER_BLOCK(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_cycles(cmd_cycles), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rdr_full_blocks(rdr_full_blocks), .rdr_partial_cycles(rdr_partial_cycles),
    .rdr_start(rdr_start), .rdr_idle(rdr_idle),
    .done_cycles(done_cycles), .done_seq(done_seq), .done_valid(done_valid),
    .done_ready(done_ready), .jobs_completed(jobs_completed), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int rdr_lat = 3;
  bit rand_lat = 1'b0;
  int busy_cnt = 0;
  logic [15:0] exp_seq = '0;

  // Reader model: drops idle while start is seen, stays busy for a latency,
  // then raises idle again. It shares the sequencer reset.
  always @(negedge clk) begin
    if (!resetn) begin
      rdr_idle = 1'b1;
      busy_cnt = 0;
    end else if (rdr_start) begin
      start_cnt++;
      rdr_idle = 1'b0;
      busy_cnt = rand_lat ? int'($urandom_range(1, 6)) : rdr_lat;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) rdr_idle = 1'b1;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Called and returns just after a negedge; acceptance edge is the posedge
  // immediately before the return.
  task automatic push(input logic [31:0] c);
    bit rdy;
    int t = 0;
    cmd_cycles = c;
    cmd_valid  = 1'b1;
    do begin
      rdy = cmd_ready;
      @(negedge clk);
      t++;
    end while (!rdy && t < 500);
    cmd_valid = 1'b0;
    if (!rdy) tmo("push");
  endtask

  task automatic collect(input logic [31:0] exp_c);
    int t = 0;
    logic [31:0] jc;
    while (!done_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!done_valid) begin
      tmo("collect");
      return;
    end
    check("done_cycles", done_cycles, exp_c);
    check("done_seq", done_seq, exp_seq);
    jc = jobs_completed;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check("jobs_completed_inc", jobs_completed, jc + 32'd1);
    check("done_valid_drop", done_valid, 1'b0);
    exp_seq++;
  endtask

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] full;
    logic [7:0]  part;
  } vec_t;

  vec_t tbl[7];

  task automatic run_job(input vec_t v);
    int sc0 = start_cnt;
    push(v.cyc);
    @(negedge clk);  // pop edge E+1 has passed
    check("full_blocks", rdr_full_blocks, v.full);
    check("partial_cycles", rdr_partial_cycles, v.part);
    if (v.cyc == 0) begin
      check("zero_done_valid", done_valid, 1'b1);
    end else begin
      check("start_early", rdr_start, 1'b0);
      @(negedge clk);
      check("start_pulse", rdr_start, 1'b1);
    end
    collect(v.cyc);
    check("start_count", start_cnt - sc0, (v.cyc != 0) ? 1 : 0);
    check("all_idle_after", all_idle, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_rdr_start"}, rdr_start, 1'b0);
    check({tag, "_done_valid"}, done_valid, 1'b0);
    check({tag, "_full"}, rdr_full_blocks, 32'd0);
    check({tag, "_partial"}, rdr_partial_cycles, 8'd0);
    check({tag, "_done_cycles"}, done_cycles, 32'd0);
    check({tag, "_done_seq"}, done_seq, 16'd0);
    check({tag, "_jobs"}, jobs_completed, 32'd0);
    check({tag, "_all_idle"}, all_idle, rdr_idle);
  endtask

  logic [31:0] bp_cyc [5];
  int unsigned rc;
  int push_sum = 0, done_sum = 0, nz = 0, sc0 = 0;
  logic [31:0] jc0;
  bit held_ok;

  initial begin
    tbl[0] = '{32'd200,        32'd3,        8'd8};
    tbl[1] = '{32'd128,        32'd2,        8'd0};
    tbl[2] = '{32'd5,          32'd0,        8'd5};
    tbl[3] = '{32'd0,          32'd0,        8'd0};
    tbl[4] = '{32'd64,         32'd1,        8'd0};
    tbl[5] = '{32'd63,         32'd0,        8'd63};
    tbl[6] = '{32'hFFFF_FFFF,  32'h03FF_FFFF, 8'd63};
    bp_cyc[0] = 32'd10; bp_cyc[1] = 32'd0; bp_cyc[2] = 32'd70;
    bp_cyc[3] = 32'd1;  bp_cyc[4] = 32'd300;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    resetn = 1'b1;
    @(negedge clk);

    // table-driven single jobs, reader latency 5
    rdr_lat = 5;
    for (int i = 0; i < 7; i++) run_job(tbl[i]);

    // backpressure: five back-to-back commands with done_ready low
    rdr_lat = 3;
    done_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(bp_cyc[i]);
    check("bp_cmd_ready_low", cmd_ready, 1'b0);
    cmd_cycles = 32'd7;
    cmd_valid  = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) held_ok = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_sixth_held", held_ok, 1'b1);
    check("bp_stall_valid", done_valid, 1'b1);
    repeat (4) @(negedge clk);
    check("bp_stall_valid_hold", done_valid, 1'b1);
    check("bp_stall_cycles", done_cycles, bp_cyc[0]);
    check("bp_stall_seq", done_seq, exp_seq);
    for (int i = 0; i < 5; i++) collect(bp_cyc[i]);
    check("bp_all_idle", all_idle, 1'b1);

    // reset in the middle of WAIT with two jobs queued
    rdr_lat = 50;
    push(32'd100);
    push(32'd20);
    push(32'd30);
    repeat (10) @(negedge clk);
    check("mid_in_wait", rdr_idle, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk);
    resetn = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_valid || rdr_start) held_ok = 1'b0;
    end
    check("midrst_no_done", held_ok, 1'b1);
    check("midrst_all_idle", all_idle, 1'b1);
    exp_seq = '0;
    rdr_lat = 3;
    run_job('{32'd9, 32'd0, 8'd9});

    // randomized backpressure and reader latency over 1000 jobs
    rand_lat = 1'b1;
    sc0 = start_cnt;
    jc0 = jobs_completed;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          rc = $urandom_range(0, 600);
          if ($urandom_range(0, 9) == 0) rc = 0;
          push_sum += int'(rc);
          if (rc != 0) nz++;
          push(rc);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 60000) begin
          done_ready = $urandom_range(0, 1) == 1;
          if (done_valid && done_ready) begin
            done_sum += int'(done_cycles);
            check("rand_seq", done_seq, exp_seq);
            exp_seq++;
            got++;
          end
          @(negedge clk);
          cyc++;
        end
        done_ready = 1'b0;
        if (got < 1000) tmo("rand_collect");
      end
    join
    @(negedge clk);
    check("rand_jobs_completed", jobs_completed - jc0, 32'd1000);
    check("rand_sum", done_sum, push_sum);
    check("rand_starts", start_cnt - sc0, nz);
    check("rand_all_idle", all_idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
